register_universal_serializer: RTL and testbench

Parametrised universal shift register with an automatic parallel-to-serial frame engine. Idle: a 3-bit opcode selects hold, load, shift, rotate or clear on a WIDTH-bit register. A start strobe loads a parallel word and shifts it out one bit per clock, with busy/done status. It sits between parallel datapaths and bit-serial links (UART/SPI-style transmitters) in the sequential library.

---
 rtl/register_pkg.sv | 20 ++
 rtl/counter_down_load.sv | 34 +++
 rtl/register_universal_serializer.sv | 129 ++++++++++++
 tb/tb_register_universal_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared definitions for the universal shift register / serializer.
//   - 3-bit manual opcodes applied while the engine is idle
//   - FSM state encoding for the frame engine
package register_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/counter_down_load.sv
// Loadable down-counter with zero flag, used as the frame bit counter.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset (count -> 0)
//   load       load load_value (priority over enable)
//   enable     decrement by one; saturates at zero
//   load_value value taken on load
//   zero       high while count == 0
module counter_down_load #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/register_universal_serializer.sv
// Universal shift register with an automatic parallel-to-serial frame engine.
// Idle: op selects hold/load/shift/rotate/clear. A start strobe loads data_in
// and shifts it out one bit per clock on data_out, with busy/done status.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-low reset
//   op        manual opcode, honoured only when idle and start=0
//   data_in   parallel load word (LOAD and start)
//   sr        fill bit entering q[WIDTH-1] on right shift
//   sl        fill bit entering q[0] on left shift
//   start     begin a serial frame with data_in (priority over op)
//   q         register contents
//   data_out  serial output: q[0] (LSB first) or q[WIDTH-1] (MSB first)
//   busy      frame in progress
//   done      one-cycle pulse after the last frame bit
module register_universal_serializer
  import register_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr,
  input  logic             sl,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic fill);
    return {fill, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic fill);
    return {v[WIDTH-2:0], fill};
  endfunction

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] frame_shift;
  logic             done_next;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;

  counter_down_load #(
    .W(CNT_W)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .enable     (cnt_en),
    .load_value (CNT_W'(WIDTH - 1)),
    .zero       (cnt_zero)
  );

  // Frame direction is fixed at elaboration: LSB first shifts right with sr,
  // MSB first shifts left with sl.
  assign frame_shift = MSB_FIRST ? shift_left(q, sl) : shift_right(q, sr);

  always_comb begin
    state_next = state;
    q_next     = q;
    done_next  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          q_next     = data_in;
          cnt_load   = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          case (op)
            OP_LOAD: q_next = data_in;
            OP_SHR:  q_next = shift_right(q, sr);
            OP_SHL:  q_next = shift_left(q, sl);
            OP_ROR:  q_next = shift_right(q, q[0]);
            OP_ROL:  q_next = shift_left(q, q[WIDTH-1]);
            OP_CLR:  q_next = '0;
            default: q_next = q;
          endcase
        end
      end
      ST_SHIFT: begin
        q_next = frame_shift;
        if (cnt_zero) begin
          done_next = 1'b1;
          // A start seen on the terminal edge chains the next frame with no
          // idle gap; the final shift result is replaced by the new word.
          if (start) begin
            q_next   = data_in;
            cnt_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      done  <= done_next;
    end
  end

  assign busy     = (state == ST_SHIFT);
  assign data_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_register_universal_serializer.sv
module tb_register_universal_serializer;

  logic clock;
  logic reset;

  // WIDTH=4, LSB first
  logic [2:0] op4;
  logic [3:0] d4, q4;
  logic       sr4, sl4, start4, dout4, busy4, done4;
  // WIDTH=8, LSB first
  logic [2:0] op8l;
  logic [7:0] d8l, q8l;
  logic       sr8l, sl8l, start8l, dout8l, busy8l, done8l;
  // WIDTH=8, MSB first
  logic [2:0] op8m;
  logic [7:0] d8m, q8m;
  logic       sr8m, sl8m, start8m, dout8m, busy8m, done8m;

  int errors = 0;
  int checks = 0;

  // Hand-computed expected sequences.
  logic seq_b4_lsb [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic seq_b4_msb [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic seq_5a_lsb [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] q_b4_msb_fill1 [8] = '{8'hB4, 8'h69, 8'hD3, 8'hA7,
                                     8'h4F, 8'h9F, 8'h3F, 8'h7F};

  register_universal_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4 (
    .clock(clock), .reset(reset), .op(op4), .data_in(d4), .sr(sr4), .sl(sl4),
    .start(start4), .q(q4), .data_out(dout4), .busy(busy4), .done(done4));

  register_universal_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_w8l (
    .clock(clock), .reset(reset), .op(op8l), .data_in(d8l), .sr(sr8l), .sl(sl8l),
    .start(start8l), .q(q8l), .data_out(dout8l), .busy(busy8l), .done(done8l));

  register_universal_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8m (
    .clock(clock), .reset(reset), .op(op8m), .data_in(d8m), .sr(sr8m), .sl(sl8m),
    .start(start8m), .q(q8m), .data_out(dout8m), .busy(busy8m), .done(done8m));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op4_from_1001(input logic [2:0] o, input logic s_r, input logic s_l);
    op4 = 3'd1; d4 = 4'b1001;
    step();
    op4 = o; sr4 = s_r; sl4 = s_l;
    step();
    op4 = 3'd0;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0;
    op4 = 3'd0; d4 = '0; sr4 = 1'b0; sl4 = 1'b0; start4 = 1'b0;
    op8l = 3'd0; d8l = '0; sr8l = 1'b0; sl8l = 1'b0; start8l = 1'b0;
    op8m = 3'd0; d8m = '0; sr8m = 1'b0; sl8m = 1'b0; start8m = 1'b0;

    repeat (2) step();
    chk("rst_q4", 32'(q4), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);
    reset = 1'b1;

    // ---- WIDTH=4: reset mid-frame ----
    op4 = 3'd1; d4 = 4'h5;
    step();
    op4 = 3'd0;
    chk("load5_q4", 32'(q4), 32'h5);
    start4 = 1'b1; d4 = 4'hF;
    step();
    start4 = 1'b0;
    chk("start_busy4", 32'(busy4), 32'h1);
    chk("start_q4", 32'(q4), 32'hF);
    step();
    chk("shift1_q4", 32'(q4), 32'h7);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_q4", 32'(q4), 32'h0);
    chk("async_rst_busy4", 32'(busy4), 32'h0);
    chk("async_rst_done4", 32'(done4), 32'h0);
    chk("async_rst_dout4", 32'(dout4), 32'h0);
    #1 reset = 1'b1;
    op4 = 3'd1; d4 = 4'hA;
    step();
    op4 = 3'd0;
    chk("post_rst_load_q4", 32'(q4), 32'hA);
    chk("abort_no_done_a", 32'(done4), 32'h0);
    step();
    chk("abort_no_done_b", 32'(done4), 32'h0);
    chk("idle_hold_q4", 32'(q4), 32'hA);

    // ---- WIDTH=4: manual opcodes from 1001 ----
    op4_from_1001(3'd4, 1'b0, 1'b0);
    chk("ror_q4", 32'(q4), 32'hC);
    op4_from_1001(3'd5, 1'b0, 1'b0);
    chk("rol_q4", 32'(q4), 32'h3);
    op4_from_1001(3'd2, 1'b1, 1'b0);
    chk("shr_sr1_q4", 32'(q4), 32'hC);
    op4_from_1001(3'd3, 1'b0, 1'b0);
    chk("shl_sl0_q4", 32'(q4), 32'h2);
    op4_from_1001(3'd6, 1'b0, 1'b0);
    chk("clr_q4", 32'(q4), 32'h0);
    op4_from_1001(3'd7, 1'b1, 1'b1);
    chk("op7_hold_q4", 32'(q4), 32'h9);
    chk("op7_busy4", 32'(busy4), 32'h0);

    // ---- WIDTH=8 LSB first: frame 0xB4 then back-to-back 0x5A ----
    start8l = 1'b1; d8l = 8'hB4; sr8l = 1'b0;
    step();
    start8l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b4l_dout_%0d", k), 32'(dout8l), 32'(seq_b4_lsb[k]));
      chk($sformatf("b4l_busy_%0d", k), 32'(busy8l), 32'h1);
      chk($sformatf("b4l_done_%0d", k), 32'(done8l), 32'h0);
      if (k == 7) begin
        start8l = 1'b1; d8l = 8'h5A;
      end
      step();
      start8l = 1'b0;
    end
    chk("b2b_busy", 32'(busy8l), 32'h1);
    chk("b2b_done", 32'(done8l), 32'h1);
    chk("b2b_q", 32'(q8l), 32'h5A);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("5al_dout_%0d", k), 32'(dout8l), 32'(seq_5a_lsb[k]));
      chk($sformatf("5al_busy_%0d", k), 32'(busy8l), 32'h1);
      if (k > 0) chk($sformatf("5al_done_%0d", k), 32'(done8l), 32'h0);
      step();
    end
    chk("5al_end_busy", 32'(busy8l), 32'h0);
    chk("5al_end_done", 32'(done8l), 32'h1);
    chk("5al_end_q", 32'(q8l), 32'h0);
    step();
    chk("5al_done_drop", 32'(done8l), 32'h0);

    // ---- WIDTH=8 LSB first: single frame, sr=0, final q=0 ----
    start8l = 1'b1; d8l = 8'hB4; sr8l = 1'b0;
    step();
    start8l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b4l2_dout_%0d", k), 32'(dout8l), 32'(seq_b4_lsb[k]));
      step();
    end
    chk("b4l2_busy_end", 32'(busy8l), 32'h0);
    chk("b4l2_done", 32'(done8l), 32'h1);
    chk("b4l2_q", 32'(q8l), 32'h0);
    step();
    chk("b4l2_done_drop", 32'(done8l), 32'h0);

    // ---- WIDTH=8 MSB first, sl=1, with op=6 and start toggling mid-frame ----
    start8m = 1'b1; op8m = 3'd6; d8m = 8'hB4; sl8m = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b4m_q_%0d", k), 32'(q8m), 32'(q_b4_msb_fill1[k]));
      chk($sformatf("b4m_dout_%0d", k), 32'(dout8m), 32'(seq_b4_msb[k]));
      chk($sformatf("b4m_busy_%0d", k), 32'(busy8m), 32'h1);
      start8m = (k < 7) ? k[0] : 1'b0;
      d8m = 8'h00;
      step();
    end
    op8m = 3'd0; start8m = 1'b0;
    chk("b4m_q_final", 32'(q8m), 32'hFF);
    chk("b4m_done", 32'(done8m), 32'h1);
    chk("b4m_busy_end", 32'(busy8m), 32'h0);
    step();
    chk("b4m_done_drop", 32'(done8m), 32'h0);
    chk("b4m_idle_hold", 32'(q8m), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
